// File: rtl/hp_mul_round.sv
// hp_mul_round: binary16 multiplier normalize/round-to-nearest-even/pack stage on a two-stage valid/ready pipeline.
// Build option HP_MUL_SUBNORMAL_EN selects gradual underflow; left undefined, tiny results flush to signed zero.
module hp_mul_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [21:0] in_p,
    input  logic [6:0]  in_exp,
    input  logic        in_sign,
    input  logic [1:0]  in_cls,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_z,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inx
);

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } cls_e;

    logic              s1_valid_q, s1_valid_d;
    logic [9:0]        s1_mant_q,  s1_mant_d;
    logic              s1_g_q,     s1_g_d;
    logic              s1_st_q,    s1_st_d;
    logic signed [7:0] s1_exp_q,   s1_exp_d;
    logic              s1_sign_q,  s1_sign_d;
    cls_e              s1_cls_q,   s1_cls_d;

    logic              s2_valid_q, s2_valid_d;
    logic [15:0]       z_q,        z_d;
    logic              ovf_q,      ovf_d;
    logic              unf_q,      unf_d;
    logic              inx_q,      inx_d;

    logic              s2_load, s1_take, s2_take;
    logic signed [7:0] in_exp_ext;

    // Handshake: s2 frees up combinationally when the consumer takes its beat.
    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_load;
        s1_take  = in_valid && in_ready;
        s2_take  = s1_valid_q && s2_load;
    end

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        in_exp_ext = {in_exp[6], in_exp};
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_g_d     = s1_g_q;
        s1_st_d    = s1_st_q;
        s1_exp_d   = s1_exp_q;
        s1_sign_d  = s1_sign_q;
        s1_cls_d   = s1_cls_q;
        if (s1_take) begin
            if (in_p[21]) begin
                s1_mant_d = in_p[20:11];
                s1_g_d    = in_p[10];
                s1_st_d   = |in_p[9:0];
                s1_exp_d  = in_exp_ext + 8'sd16;
            end else begin
                s1_mant_d = in_p[19:10];
                s1_g_d    = in_p[9];
                s1_st_d   = |in_p[8:0];
                s1_exp_d  = in_exp_ext + 8'sd15;
            end
            s1_sign_d = in_sign;
            s1_cls_d  = cls_e'(in_cls);
        end
    end

    logic        norm_rnd;
    logic [10:0] norm_sum;
    logic [4:0]  norm_exp;
    logic [15:0] rp_z;
    logic        rp_ovf, rp_unf, rp_inx;

`ifdef HP_MUL_SUBNORMAL_EN
    logic [7:0]  sub_sh;
    logic [23:0] sub_v;
    logic [10:0] sub_m, sub_sum;
    logic        sub_g, sub_st, sub_rnd;

    // Denormalize {1,mant}; the 12 zero pad bits absorb every shift up to 12 without loss.
    always_comb begin
        sub_sh = 8'sd1 - s1_exp_q;
        sub_v  = {1'b1, s1_mant_q, s1_g_q, 12'b0} >> sub_sh[3:0];
        if (sub_sh > 8'd12) begin
            sub_m  = '0;
            sub_g  = 1'b0;
            sub_st = 1'b1;
        end else begin
            sub_m  = sub_v[23:13];
            sub_g  = sub_v[12];
            sub_st = (|sub_v[11:0]) | s1_st_q;
        end
        sub_rnd = sub_g & (sub_st | sub_m[0]);
        sub_sum = sub_m + {10'b0, sub_rnd};
    end
`endif

    always_comb begin
        norm_rnd = s1_g_q & (s1_st_q | s1_mant_q[0]);
        norm_sum = {1'b0, s1_mant_q} + {10'b0, norm_rnd};
        norm_exp = s1_exp_q[4:0] + {4'b0, norm_sum[10]};
        rp_z     = '0;
        rp_ovf   = 1'b0;
        rp_unf   = 1'b0;
        rp_inx   = 1'b0;
        case (s1_cls_q)
            CLS_ZERO: rp_z = {s1_sign_q, 15'h0000};
            CLS_INF:  rp_z = {s1_sign_q, 15'h7C00};
            CLS_NAN:  rp_z = 16'h7E00;
            default: begin
                rp_inx = s1_g_q | s1_st_q;
                if (s1_exp_q >= 8'sd31) begin
                    rp_z   = {s1_sign_q, 15'h7C00};
                    rp_ovf = 1'b1;
                    rp_inx = 1'b1;
                end else if (s1_exp_q >= 8'sd1) begin
                    if (norm_exp == 5'd31) begin
                        rp_z   = {s1_sign_q, 15'h7C00};
                        rp_ovf = 1'b1;
                    end else begin
                        // A mantissa carry leaves norm_sum[9:0] zero, so no separate clear is needed.
                        rp_z = {s1_sign_q, norm_exp, norm_sum[9:0]};
                    end
                end else begin
`ifdef HP_MUL_SUBNORMAL_EN
                    rp_z   = {s1_sign_q, 4'b0, sub_sum};
                    rp_inx = sub_g | sub_st;
                    rp_unf = !sub_sum[10] && (sub_g || sub_st);
`else
                    rp_z   = {s1_sign_q, 15'h0000};
                    rp_unf = 1'b1;
                    rp_inx = 1'b1;
`endif
                end
            end
        endcase
    end

    // Result registers only move on a real capture, so a stalled output stays put.
    always_comb begin
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        z_d        = s2_take ? rp_z   : z_q;
        ovf_d      = s2_take ? rp_ovf : ovf_q;
        unf_d      = s2_take ? rp_unf : unf_q;
        inx_d      = s2_take ? rp_inx : inx_q;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mant_q  <= '0;
            s1_g_q     <= 1'b0;
            s1_st_q    <= 1'b0;
            s1_exp_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_cls_q   <= CLS_NORMAL;
            s2_valid_q <= 1'b0;
            z_q        <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mant_q  <= s1_mant_d;
            s1_g_q     <= s1_g_d;
            s1_st_q    <= s1_st_d;
            s1_exp_q   <= s1_exp_d;
            s1_sign_q  <= s1_sign_d;
            s1_cls_q   <= s1_cls_d;
            s2_valid_q <= s2_valid_d;
            z_q        <= z_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inx_q      <= inx_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_z     = z_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;
    assign out_inx   = inx_q;

endmodule

// File: doc/hp_mul_round.md
# hp_mul_round

Pipelined normalize-round-pack stage for the IEEE 754 binary16 multiplier. It sits directly downstream of the 11×11 significand multiplier and takes that block's 22-bit unsigned product. It also takes the sign, the unbiased exponent sum and an operand class from the exponent/sign path. It produces a packed binary16 result with round-to-nearest-even and exception flags, over a two-stage valid/ready pipeline.

## Interface
- No parameters; widths are fixed to binary16 (NSIG = 10, bias 15).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_p  in  22  significand product; for class NORMAL, upstream guarantees in_p[21] or in_p[20] is set
- in_exp  in  7  signed unbiased exponent sum, range −28..+30
- in_sign  in  1  result sign (sign_a ^ sign_b)
- in_cls  in  2  00 NORMAL, 01 ZERO, 10 INF, 11 NaN (already resolved upstream, e.g. 0×inf → NaN)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result this cycle
- out_z  out  16  binary16 result
- out_ovf  out  1  overflow flag
- out_unf  out  1  underflow flag (tiny and inexact, or flushed)
- out_inx  out  1  inexact flag

## Operation
- Stage 1 (normalize), registered:
  - If in_p[21]: mant = in_p[20:11], g = in_p[10], st = |in_p[9:0], e = in_exp + 1.
  - Otherwise: mant = in_p[19:10], g = in_p[9], st = |in_p[8:0], e = in_exp.
  - Biased exponent E = e + 15, held as 8-bit signed.
- Stage 2 (round/pack), registered:
  - NORMAL with 1 ≤ E ≤ 30: rnd = g & (st | mant[0]); {c, m} = mant + rnd.
    - If c = 1: m = 0 and E = E + 1.
    - If the incremented E is 31: result is inf, out_ovf = 1.
  - NORMAL with E ≥ 31: result is sign|0x7C00, out_ovf = 1, out_inx = 1.
  - NORMAL with E ≤ 0: handling depends on the configuration below.
  - out_inx = g | st for every NORMAL result.
  - ZERO → sign|0x0000. INF → sign|0x7C00. NaN → 0x7E00 (canonical, sign forced to 0).
  - Non-NORMAL classes clear all flags.
- Handshake:
  - s2 loads when !s2_valid | out_ready.
  - in_ready = !s1_valid | (s2 load enable). This is combinational from out_ready.
  - A beat transfers when valid & ready are both high on a clock edge.
  - While a beat is held at the output, out_z and the flags stay stable.
- Reset (asynchronous, any time including mid-stream):
  - s1_valid = 0, out_valid = 0, out_z = 0x0000, all flags = 0.
  - In-flight beats are discarded. in_ready = 1 while in reset.

## Timing
- Latency is 2 cycles: a beat accepted at edge N is visible on out_* after edge N+1 and transfers at edge N+2 at the earliest.
- Throughput is 1 beat/cycle with out_ready held high.
- With out_ready low, at most 2 beats are buffered; in_ready drops once both stages are full.
- Releasing out_ready restores in_ready in the same cycle (pass-through).
- When a transfer in and a transfer out happen in the same cycle with both stages full, both transfers occur and no bubble is inserted.

## Configuration
- Macro HP_MUL_SUBNORMAL_EN, controlling the NORMAL, E ≤ 0 case.
- Defined (gradual underflow):
  - Shift {1, mant} right by (1 − E); shifts greater than 12 collapse entirely into st.
  - Shifted-out bits feed g/st; round with RNE.
  - Pack the result with exponent field 0, or 1 if rounding carries into the hidden bit.
  - out_unf = (result is subnormal or zero) & inexact.
- Undefined (flush to zero):
  - Result is sign|0x0000, out_unf = 1, out_inx = 1.

## Test plan
- in_p = 0x240000, in_exp = 0, in_sign = 0, NORMAL → out_z = 0x4080 (2.25), flags all 0, out_valid 2 cycles after acceptance.
- Tie cases, NORMAL, in_exp = 0:
  - in_p = 0x100200 → out_z = 0x3C00, out_inx = 1 (tie to even, no increment).
  - in_p = 0x100600 → out_z = 0x3C02, out_inx = 1.
- in_p = 0x200000, in_exp = 15, sign = 1 → out_z = 0xFC00, out_ovf = 1, out_inx = 1. Classes INF/NaN/ZERO → 0x7C00|sign, 0x7E00, sign|0, with no flags.
- in_p = 0x100000, in_exp = −15 (E = 0):
  - Without macro → 0x0000, out_unf = 1.
  - With HP_MUL_SUBNORMAL_EN → 0x0200, flags 0.
- Backpressure:
  - Hold out_ready = 0 and offer 3 back-to-back beats → only 2 are accepted, in_ready = 0, out_z held stable.
  - Raise out_ready → all 3 results emerge in order with no loss or duplication.
- Assert rst for 1 cycle while both stages are full → out_valid = 0 and out_z = 0 immediately (asynchronous). The next beat after reset completes normally.
